// File: rtl/muldiv_sched_pkg.sv
// Shared definitions for the muldiv issue scheduler: default parameter
// values, source-index width helper and the performance counter type.
package muldiv_sched_pkg;

    localparam int DEF_NUM_ROUND_BITS = 8;
    localparam int DEF_EXP_WIDTH      = 8;
    localparam int DEF_MANT_WIDTH     = 23;
    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_TAG_W          = 4;
    localparam int DEF_BUF_DEPTH      = 2;

    typedef logic [31:0] perf_cnt_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int src_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// Request/response bundle between the operand-decode lanes, the scheduler
// and the normalise stage. master = requesters + consumer, slave = scheduler.
interface muldiv_sched_if
    import muldiv_sched_pkg::*;
#(
    parameter int exp_width  = DEF_EXP_WIDTH,
    parameter int mant_width = DEF_MANT_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int TAG_W      = DEF_TAG_W
);
    localparam int SRC_W = src_idx_w(NUM_REQ);
    localparam int EW2   = exp_width + 2;
    localparam int PW    = 2 * mant_width + 2;

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][mant_width-1:0] req_mant_a;
    logic [NUM_REQ-1:0][mant_width-1:0] req_mant_b;
    logic [NUM_REQ-1:0][EW2-1:0]        req_exp_a;
    logic [NUM_REQ-1:0][EW2-1:0]        req_exp_b;
    logic [NUM_REQ-1:0][EW2-1:0]        req_lz;
    logic [NUM_REQ-1:0]                 req_clz_shift;
    logic [NUM_REQ-1:0][TAG_W-1:0]      req_tag;

    logic                               rsp_valid;
    logic                               rsp_ready;
    logic [PW-1:0]                      rsp_mant;
    logic [EW2-1:0]                     rsp_exp;
    logic [TAG_W-1:0]                   rsp_tag;
    logic [SRC_W-1:0]                   rsp_src;

    modport master (
        output req_valid, req_mant_a, req_mant_b, req_exp_a, req_exp_b,
               req_lz, req_clz_shift, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_mant, rsp_exp, rsp_tag, rsp_src
    );

    modport slave (
        input  req_valid, req_mant_a, req_mant_b, req_exp_a, req_exp_b,
               req_lz, req_clz_shift, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_mant, rsp_exp, rsp_tag, rsp_src
    );

endinterface

// File: rtl/muldiv.sv
// Mantissa/exponent multiply datapath. Forms the full unnormalised product
// of the two significands (hidden bit restored for normals, subnormal A
// pre-shifted by lz+1) and the matching exponent sum.
module muldiv #(
    parameter int num_round_bits = 8,
    parameter int exp_width      = 8,
    parameter int mant_width     = 23
) (
    input  logic [mant_width-1:0]     mant_a,
    input  logic [mant_width-1:0]     mant_b,
    input  logic [exp_width+1:0]      exp_a,
    input  logic [exp_width+1:0]      exp_b,
    input  logic [exp_width+1:0]      lz,
    input  logic                      clz_shift,
    output logic [2*mant_width+1:0]   mant,
    output logic [exp_width+1:0]      exp
);
    localparam int EW2 = exp_width + 2;
    localparam int PW  = 2 * mant_width + 2;

    // Rounding happens downstream; a negative count is a configuration error.
    if (num_round_bits < 0) begin : g_bad_round_bits
        $error("muldiv: num_round_bits must be non-negative");
    end

    logic [mant_width:0] sig_a;
    logic [mant_width:0] sig_b;
    logic [EW2-1:0]      shamt;
    logic [EW2-1:0]      exp_a_n;

    // Significand formation and two's-complement exponent arithmetic.
    always_comb begin
        shamt = lz + EW2'(1);
        sig_b = {1'b1, mant_b};
        if (clz_shift) begin
            sig_a   = {1'b0, mant_a} << shamt;
            exp_a_n = exp_a - shamt;
        end else begin
            sig_a   = {1'b1, mant_a};
            exp_a_n = exp_a;
        end
        mant = PW'(sig_a) * PW'(sig_b);
        exp  = exp_a_n + exp_b;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted requester,
// grant is gated by en, and the pointer moves only when a grant is issued.
module rr_arbiter
    import muldiv_sched_pkg::*;
#(
    parameter int N = DEF_NUM_REQ,
    localparam int IW = src_idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic [IW-1:0] last_q, last_d;
    logic          found;
    logic [IW-1:0] k_idx;

    // First requester at or after last+1 wins; nothing is granted without en.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k_idx   = '0;
        for (int i = 0; i < N; i++) begin
            k_idx = IW'((int'(last_q) + 1 + i) % N);
            if (!found && req[k_idx]) begin
                found      = 1'b1;
                gnt[k_idx] = en;
                gnt_idx    = k_idx;
            end
        end
    end

    // Remember the winner only on an actual grant.
    always_comb begin
        last_d = (|gnt) ? gnt_idx : last_q;
    end

    // Reset parks the pointer on the last index so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (rst) last_q <= IW'(N - 1);
        else     last_q <= last_d;
    end

endmodule

// File: rtl/muldiv_sched.sv
// Issue scheduler sharing one muldiv datapath among NUM_REQ requesters:
// round-robin grant with buffer credit, one issue register (S0), and a
// small response FIFO absorbing consumer backpressure. Latency is 2.
// Optional MULDIV_SCHED_PERF_EN adds per-requester grant and stall counters.
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int num_round_bits = DEF_NUM_ROUND_BITS,
    parameter int exp_width      = DEF_EXP_WIDTH,
    parameter int mant_width     = DEF_MANT_WIDTH,
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TAG_W          = DEF_TAG_W,
    parameter int BUF_DEPTH      = DEF_BUF_DEPTH
) (
    input logic           clk,
    input logic           rst,
    muldiv_sched_if.slave bus
`ifdef MULDIV_SCHED_PERF_EN
    ,
    output perf_cnt_t [NUM_REQ-1:0] perf_grant,
    output perf_cnt_t               perf_stall
`endif
);
    localparam int SRC_W  = src_idx_w(NUM_REQ);
    localparam int EW2    = exp_width + 2;
    localparam int PW     = 2 * mant_width + 2;
    localparam int BUF_IW = $clog2(BUF_DEPTH);
    localparam int OCC_W  = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [mant_width-1:0] mant_a;
        logic [mant_width-1:0] mant_b;
        logic [EW2-1:0]        exp_a;
        logic [EW2-1:0]        exp_b;
        logic [EW2-1:0]        lz;
        logic                  clz_shift;
        logic [TAG_W-1:0]      tag;
        logic [SRC_W-1:0]      src;
    } s0_t;

    typedef struct packed {
        logic [PW-1:0]    mant;
        logic [EW2-1:0]   exp;
        logic [TAG_W-1:0] tag;
        logic [SRC_W-1:0] src;
    } rsp_t;

    function automatic logic [BUF_IW-1:0] ptr_inc(input logic [BUF_IW-1:0] p);
        return (int'(p) == BUF_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    logic [NUM_REQ-1:0] gnt;
    logic [SRC_W-1:0]   gnt_idx;
    logic               transfer, pop, push, credit_ok, arb_en;

    logic               s0_valid_q, s0_valid_d;
    s0_t                s0_q, s0_d;
    logic [PW-1:0]      md_mant;
    logic [EW2-1:0]     md_exp;

    rsp_t               mem_q [BUF_DEPTH];
    rsp_t               mem_d [BUF_DEPTH];
    logic [BUF_IW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    rsp_t               head;

    // Credit counts the slot freed by a same-cycle pop and the one S0 will
    // consume, so a full buffer being drained can still accept a grant.
    always_comb begin
        pop       = (occ_q != '0) && bus.rsp_ready;
        push      = s0_valid_q;
        credit_ok = (int'(occ_q) - int'(pop) + int'(s0_valid_q)) < BUF_DEPTH;
        arb_en    = credit_ok && !rst;
        transfer  = |gnt;
    end

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign bus.req_ready = gnt;

    // Issue stage: capture the winner's payload; valid lives for one cycle.
    always_comb begin
        s0_valid_d = transfer;
        s0_d       = s0_q;
        if (transfer) begin
            s0_d.mant_a    = bus.req_mant_a[gnt_idx];
            s0_d.mant_b    = bus.req_mant_b[gnt_idx];
            s0_d.exp_a     = bus.req_exp_a[gnt_idx];
            s0_d.exp_b     = bus.req_exp_b[gnt_idx];
            s0_d.lz        = bus.req_lz[gnt_idx];
            s0_d.clz_shift = bus.req_clz_shift[gnt_idx];
            s0_d.tag       = bus.req_tag[gnt_idx];
            s0_d.src       = gnt_idx;
        end
    end

    muldiv #(
        .num_round_bits (num_round_bits),
        .exp_width      (exp_width),
        .mant_width     (mant_width)
    ) u_muldiv (
        .mant_a    (s0_q.mant_a),
        .mant_b    (s0_q.mant_b),
        .exp_a     (s0_q.exp_a),
        .exp_b     (s0_q.exp_b),
        .lz        (s0_q.lz),
        .clz_shift (s0_q.clz_shift),
        .mant      (md_mant),
        .exp       (md_exp)
    );

    // Response FIFO: write the datapath result behind S0, pop on handshake.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = '{mant: md_mant, exp: md_exp, tag: s0_q.tag, src: s0_q.src};
            wr_d        = ptr_inc(wr_q);
        end
        if (pop) rd_d = ptr_inc(rd_q);
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    // S0 and buffer state; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_q       <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            occ_q      <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_q       <= s0_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            occ_q      <= occ_d;
            mem_q      <= mem_d;
        end
    end

    assign head          = mem_q[rd_q];
    assign bus.rsp_valid = (occ_q != '0);
    assign bus.rsp_mant  = bus.rsp_valid ? head.mant : '0;
    assign bus.rsp_exp   = bus.rsp_valid ? head.exp  : '0;
    assign bus.rsp_tag   = bus.rsp_valid ? head.tag  : '0;
    assign bus.rsp_src   = bus.rsp_valid ? head.src  : '0;

    no_overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && occ_q == OCC_W'(BUF_DEPTH)));

`ifdef MULDIV_SCHED_PERF_EN
    perf_cnt_t [NUM_REQ-1:0] perf_grant_q, perf_grant_d;
    perf_cnt_t               perf_stall_q, perf_stall_d;

    // Count transfers per requester and cycles where demand went unserved.
    always_comb begin
        perf_grant_d = perf_grant_q;
        perf_stall_d = perf_stall_q;
        if (transfer) perf_grant_d[gnt_idx] = perf_grant_q[gnt_idx] + 32'd1;
        if ((|bus.req_valid) && !transfer) perf_stall_d = perf_stall_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_grant_q <= perf_grant_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_grant = perf_grant_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed values. Builds with or without
// MULDIV_SCHED_PERF_EN.
module tb_muldiv_sched;
    import muldiv_sched_pkg::*;

    localparam int NR        = 2;
    localparam int MW        = 23;
    localparam int BUF_DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   glog[$];
    int   rcnt   = 0;

    typedef struct {
        logic [47:0] mant;
        logic [9:0]  exp;
        logic [3:0]  tag;
        int          src;
        int          due;
    } exp_t;

    exp_t mq[$];
    int   last_g = NR - 1;
    int   pg[NR];
    int   ps = 0;

    always #5 clk = ~clk;

    muldiv_sched_if bus ();

`ifdef MULDIV_SCHED_PERF_EN
    perf_cnt_t [NR-1:0] perf_grant;
    perf_cnt_t          perf_stall;
`endif

    muldiv_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MULDIV_SCHED_PERF_EN
        ,
        .perf_grant (perf_grant),
        .perf_stall (perf_stall)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [22:0] ma, input logic [22:0] mb,
                           input int ea, input int eb, input int lz, input logic clz,
                           input logic [3:0] tag);
        bus.req_mant_a[r]    = ma;
        bus.req_mant_b[r]    = mb;
        bus.req_exp_a[r]     = 10'(ea);
        bus.req_exp_b[r]     = 10'(eb);
        bus.req_lz[r]        = 10'(lz);
        bus.req_clz_shift[r] = clz;
        bus.req_tag[r]       = tag;
    endtask

    // Reference model: every transfer becomes an expected response due two
    // cycles later; responses leave in grant order when the consumer accepts.
    initial begin : cmp
        exp_t        e;
        int          g, lzv, eav;
        logic [NR-1:0] er;
        logic        ev, popm;
        longint      sa, sb;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            ev = (mq.size() > 0) && (mq[0].due <= cyc);
            chk("rsp_valid", bus.rsp_valid, ev);
            if (ev) begin
                chk("rsp_mant", bus.rsp_mant, mq[0].mant);
                chk("rsp_exp",  bus.rsp_exp,  mq[0].exp);
                chk("rsp_tag",  bus.rsp_tag,  mq[0].tag);
                chk("rsp_src",  bus.rsp_src,  mq[0].src);
            end else begin
                chk("rsp_mant_idle", bus.rsp_mant, 0);
                chk("rsp_exp_idle",  bus.rsp_exp,  0);
                chk("rsp_tag_idle",  bus.rsp_tag,  0);
                chk("rsp_src_idle",  bus.rsp_src,  0);
            end
            popm = ev && bus.rsp_ready;
            g = -1;
            if (!rst && (mq.size() - int'(popm)) < BUF_DEPTH) begin
                for (int k = 0; k < NR; k++) begin
                    int idx;
                    idx = (last_g + 1 + k) % NR;
                    if (g < 0 && bus.req_valid[idx]) g = idx;
                end
            end
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", bus.req_ready, er);
`ifdef MULDIV_SCHED_PERF_EN
            for (int k = 0; k < NR; k++) chk("perf_grant", perf_grant[k], pg[k]);
            chk("perf_stall", perf_stall, ps);
`endif
            for (int k = 0; k < NR; k++)
                if (bus.req_valid[k] && bus.req_ready[k]) glog.push_back(k);
            if (bus.rsp_valid && bus.rsp_ready) rcnt++;

            if (rst) begin
                mq.delete();
                last_g = NR - 1;
                for (int k = 0; k < NR; k++) pg[k] = 0;
                ps = 0;
            end else begin
                if (popm) void'(mq.pop_front());
                if (g >= 0) begin
                    lzv = int'($signed(bus.req_lz[g]));
                    eav = int'($signed(bus.req_exp_a[g]));
                    if (bus.req_clz_shift[g]) begin
                        sa  = longint'(bus.req_mant_a[g]) * (longint'(1) << (lzv + 1));
                        eav = eav - lzv - 1;
                    end else begin
                        sa = longint'(bus.req_mant_a[g]) + (longint'(1) << MW);
                    end
                    sb     = longint'(bus.req_mant_b[g]) + (longint'(1) << MW);
                    e.mant = 48'(sa * sb);
                    e.exp  = 10'(eav + int'($signed(bus.req_exp_b[g])));
                    e.tag  = bus.req_tag[g];
                    e.src  = g;
                    e.due  = cyc + 2;
                    mq.push_back(e);
                    last_g = g;
                    pg[g]++;
                end else if (|bus.req_valid) begin
                    ps++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int r0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int r = 0; r < NR; r++) set_req(r, 0, 0, 0, 0, 0, 1'b0, 4'd0);
        step(2);
        rst = 1'b0;
        #1;
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_req_ready", bus.req_ready, 0);

        // Fairness: both contend for 6 cycles straight out of reset.
        set_req(0, 23'h000010, 23'h000002, 4, 5, 0, 1'b0, 4'd1);
        set_req(1, 23'h000001, 23'h000003, -3, 2, 0, 1'b0, 4'd9);
        glog.delete();
        bus.req_valid = 2'b11;
        step(6);
        bus.req_valid = 2'b00;
        chk("fair_count", glog.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < glog.size()) chk("fair_seq", glog[i], i % 2);
`ifdef MULDIV_SCHED_PERF_EN
        chk("fair_perf0", perf_grant[0], 3);
        chk("fair_perf1", perf_grant[1], 3);
`endif
        step(4);

        // Normal operands: 1.0 x 1.0 with exponents 1 and 2.
        set_req(0, 23'h0, 23'h0, 1, 2, 0, 1'b0, 4'd5);
        bus.req_valid = 2'b01;
        step(1);
        bus.req_valid = 2'b00;
        chk("norm_lat1_valid", bus.rsp_valid, 0);
        step(1);
        chk("norm_valid", bus.rsp_valid, 1);
        chk("norm_mant", bus.rsp_mant, 48'h4000_0000_0000);
        chk("norm_exp",  bus.rsp_exp, 10'd3);
        chk("norm_tag",  bus.rsp_tag, 4'd5);
        chk("norm_src",  bus.rsp_src, 0);
        step(1);
        chk("norm_drained", bus.rsp_valid, 0);

        // Subnormal A with one leading zero in the stored field.
        set_req(0, 23'h200000, 23'h0, 0, 0, 1, 1'b1, 4'd6);
        bus.req_valid = 2'b01;
        step(1);
        bus.req_valid = 2'b00;
        step(1);
        chk("sub_valid", bus.rsp_valid, 1);
        chk("sub_mant",  bus.rsp_mant, 48'h4000_0000_0000);
        chk("sub_exp",   bus.rsp_exp, 10'h3FE);
        chk("sub_tag",   bus.rsp_tag, 4'd6);
        step(3);

        // Backpressure: only BUF_DEPTH transfers while the consumer stalls.
        set_req(0, 23'h400000, 23'h000001, 7, -1, 0, 1'b0, 4'd7);
        bus.rsp_ready = 1'b0;
        glog.delete();
        r0 = rcnt;
        bus.req_valid = 2'b01;
        step(5);
        chk("bp_transfers", glog.size(), 2);
        chk("bp_ready_low", bus.req_ready, 0);
        chk("bp_held", bus.rsp_valid, 1);

        // Full buffer, empty S0: a pop frees credit for a same-cycle grant.
        bus.rsp_ready = 1'b1;
        #1;
        chk("full_pop_grant", bus.req_ready, 2'b01);
        step(1);
        bus.req_valid = 2'b00;
        step(5);
        chk("bp_total_xfer", glog.size(), 3);
        chk("bp_total_rsp", rcnt - r0, 3);

        // Reset with S0 and buffer occupied; requester 0 must regain priority.
        set_req(0, 23'h0, 23'h0, 2, 2, 0, 1'b0, 4'd3);
        set_req(1, 23'h0, 23'h0, 1, 1, 0, 1'b0, 4'd4);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b01;
        step(2);
        chk("pre_rst_valid", bus.rsp_valid, 1);
        rst = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        chk("rst_ready_zero", bus.req_ready, 0);
        step(1);
        rst = 1'b0;
        #1;
        chk("post_rst_valid", bus.rsp_valid, 0);
        chk("post_rst_mant",  bus.rsp_mant, 0);
        chk("post_rst_exp",   bus.rsp_exp, 0);
        chk("post_rst_tag",   bus.rsp_tag, 0);
        chk("post_rst_src",   bus.rsp_src, 0);
        chk("post_rst_prio",  bus.req_ready, 2'b01);
        step(1);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        step(4);
        chk("final_idle", bus.rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
